spi_slave_rx: RTL and testbench

// - Receive end of the team's 3-wire SPI link (cs, sclk, MOSI), oversampled on the system clk.
// - Frame: cs driven low, one dummy sclk period, then DATA_W bits LSB-first, then cs driven high.

---
 rtl/spi_slave_rx.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receive end of the 3-wire SPI link, oversampled on clk.
// Frames are cs low, one dummy sclk period, DATA_W bits LSB-first, cs high.
// Received words are offered on a valid/ready port with a one-word holding register.
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err pulse output.
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    WAIT_HI = 3'd0,
    IDLE    = 3'd1,
    SKIP    = 3'd2,
    SHIFT   = 3'd3,
    TAIL    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_q, sclk_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_fall;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pub_q, pub_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overrun_q, overrun_d;

  logic shift_en, last_bit, clr_cnt;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall   = !cs_s && cs_q;
  assign cs_rise   = cs_s && !cs_q;
  assign sclk_fall = !sclk_s && sclk_q;

  // Synchronisers (equal depth for all pins) plus one-clk delay for edge detection.
  // The cs chain resets low so a frame already in progress never looks like a fresh cs fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_q        <= 1'b0;
      sclk_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_q        <= cs_s;
      sclk_q      <= sclk_s;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_HI;
    else     state_q <= state_d;
  end

  // Frame FSM next state; a cs rise before the word completes aborts the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HI: if (cs_s) state_d = IDLE;
      IDLE:    if (cs_fall) state_d = SKIP;
      SKIP: begin
        if (cs_rise)        state_d = IDLE;
        else if (sclk_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise)                            state_d = IDLE;
        else if (sclk_fall && cnt_q == LAST_CNT) state_d = TAIL;
      end
      TAIL:    if (cs_rise) state_d = IDLE;
      default: state_d = WAIT_HI;
    endcase
  end

  // Frame FSM controls for the datapath.
  always_comb begin
    shift_en = 1'b0;
    last_bit = 1'b0;
    clr_cnt  = 1'b0;
    case (state_q)
      IDLE:    clr_cnt = 1'b1;
      SHIFT: begin
        shift_en = sclk_fall && !cs_rise;
        last_bit = sclk_fall && !cs_rise && (cnt_q == LAST_CNT);
      end
      default: ;
    endcase
  end

  // Datapath next state: shift in bits, then publish the completed word one clk later.
  always_comb begin
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    pub_d        = last_bit;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (clr_cnt)                  cnt_d = '0;
    else if (shift_en && !last_bit) cnt_d = cnt_q + CNT_W'(1);
    // LSB arrives first, so shifting right lands bit i at position i after DATA_W shifts.
    if (shift_en) shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
    if (pub_q) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shreg_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      pub_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      pub_q        <= pub_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Flag aborted frames and every extra sclk fall after the word completed.
  always_comb begin
    frame_err_d = 1'b0;
    if ((state_q == SKIP || state_q == SHIFT) && cs_rise) frame_err_d = 1'b1;
    if (state_q == TAIL && sclk_fall)                      frame_err_d = 1'b1;
  end

  // Frame error pulse register.
  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus random frames
// checked against a word-level model of the holding register.
module tb_spi_slave_rx;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned SS     = 2;
  localparam int          HALF   = 11;
  localparam int          LAT    = SS + 2;

  logic              clk;
  logic              rst;
  logic              cs, sclk, mosi, ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, overrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic              frame_err;
`endif

  spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs     (cs),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (ready),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err  (frame_err),
`endif
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;
  int rise_cyc = -1000;
  int vhi_cnt  = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;
  int e_ovr    = 0;
  int e_ferr   = 0;
  bit vprev    = 1'b0;
  bit coincide = 1'b0;
  logic [DATA_W-1:0] acc_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (dout_valid === 1'b1) begin
        vhi_cnt++;
        if (!vprev) rise_cyc = cyc;
      end
      vprev = (dout_valid === 1'b1);
      if (dout_valid === 1'b1 && ready === 1'b1) acc_q.push_back(dout);
      if (overrun === 1'b1) ovr_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err === 1'b1) ferr_cnt++;
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sclk period: rise with new MOSI, then fall (the sampling edge).
  task automatic sclk_period(input logic b, input bit mark_last);
    sclk = 1'b1;
    mosi = b;
    tick(HALF);
    sclk = 1'b0;
    if (mark_last) fall_cyc = cyc;
    if (mark_last && coincide) begin
      tick(LAT - 1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(HALF - LAT);
    end else begin
      tick(HALF);
    end
  endtask

  // Full cs window: dummy period then nperiods data periods (extra ones carry random bits).
  task automatic send_frame(input logic [DATA_W-1:0] w, input int nperiods);
    logic b;
    cs = 1'b0;
    tick(HALF);
    sclk_period(1'($urandom), 1'b0);
    for (int i = 0; i < nperiods; i++) begin
      if (i < int'(DATA_W)) b = w[i];
      else                  b = 1'($urandom);
      sclk_period(b, i == int'(DATA_W) - 1);
    end
    cs = 1'b1;
    tick(HALF);
  endtask

  task automatic expect_word(input string tag, input logic [DATA_W-1:0] w);
    check({tag, "_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() != 0) check(tag, 32'(acc_q.pop_front()), 32'(w));
    acc_q.delete();
  endtask

  initial begin
    int v0;
    logic [DATA_W-1:0] w;
    bit held;
    logic [DATA_W-1:0] held_w;
    bit rdy;
    int nb;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; ready = 1'b1;
    tick(3);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    rst = 1'b0;
    tick(5);

    // Basic frame, consumer always ready: one-clk valid, fixed latency.
    v0 = vhi_cnt;
    send_frame(12'hA5C, 12);
    check("a5c_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
    check("a5c_valid_width", 32'(vhi_cnt - v0), 32'd1);
    expect_word("a5c", 12'hA5C);
    check("a5c_overrun", 32'(ovr_cnt), 32'(e_ovr));

    // Two frames with consumer stalled: second is dropped with an overrun pulse.
    ready = 1'b0;
    send_frame(12'h001, 12);
    send_frame(12'hFFF, 12);
    e_ovr++;
    check("ovr_dout_held", 32'(dout), 32'h001);
    check("ovr_valid_held", 32'(dout_valid), 32'd1);
    check("ovr_pulses", 32'(ovr_cnt), 32'(e_ovr));
    ready = 1'b1;
    tick(2);
    check("ovr_valid_cleared", 32'(dout_valid), 32'd0);
    expect_word("ovr_word", 12'h001);

    // Abort after 5 data bits, then a clean frame.
    v0 = vhi_cnt;
    send_frame(12'($urandom), 5);
    e_ferr++;
    check("abort_no_valid", 32'(vhi_cnt - v0), 32'd0);
    check("abort_no_word", 32'(acc_q.size()), 32'd0);
    send_frame(12'h3C3, 12);
    expect_word("after_abort", 12'h3C3);

    // Accept of held word in the same clk as the next publish.
    ready = 1'b0;
    send_frame(12'h123, 12);
    coincide = 1'b1;
    send_frame(12'h456, 12);
    coincide = 1'b0;
    check("coinc_valid", 32'(dout_valid), 32'd1);
    check("coinc_dout", 32'(dout), 32'h456);
    check("coinc_overrun", 32'(ovr_cnt), 32'(e_ovr));
    expect_word("coinc_old", 12'h123);
    ready = 1'b1;
    tick(2);
    expect_word("coinc_new", 12'h456);

    // Overlong frame: 14 periods, first 12 bits form the word.
    w = 12'($urandom);
    send_frame(w, 14);
    e_ferr += 2;
    expect_word("overlong", w);
    check("overlong_overrun", 32'(ovr_cnt), 32'(e_ovr));

    // Reset mid-frame with a word held: everything lost, rest of frame ignored.
    ready = 1'b0;
    send_frame(12'h5A5, 12);
    cs = 1'b0;
    tick(HALF);
    sclk_period(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) sclk_period(1'b1, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    v0 = vhi_cnt;
    for (int i = 6; i < int'(DATA_W); i++) sclk_period(1'b1, 1'b0);
    cs = 1'b1;
    tick(HALF);
    check("midrst_no_valid", 32'(vhi_cnt - v0), 32'd0);
    check("midrst_no_word", 32'(acc_q.size()), 32'd0);
    ready = 1'b1;
    send_frame(12'h800, 12);
    expect_word("after_rst", 12'h800);
    check("dir_overrun_total", 32'(ovr_cnt), 32'(e_ovr));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("dir_frame_err_total", 32'(ferr_cnt), 32'(e_ferr));
`endif

    // Random frames against a word-level holding-register model.
    held = 1'b0;
    held_w = '0;
    for (int r = 0; r < 10; r++) begin
      rdy = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       nb = int'($urandom_range(1, 11));
        1:       nb = 13;
        2:       nb = 14;
        default: nb = 12;
      endcase
      w = 12'($urandom);
      ready = rdy;
      if (rdy && held) begin
        exp_q.push_back(held_w);
        held = 1'b0;
      end
      tick(2);
      send_frame(w, nb);
      if (nb < int'(DATA_W)) begin
        e_ferr++;
      end else begin
        e_ferr += nb - int'(DATA_W);
        if (rdy)       exp_q.push_back(w);
        else if (held) e_ovr++;
        else begin
          held   = 1'b1;
          held_w = w;
        end
      end
      check("rnd_valid", 32'(dout_valid), 32'(held));
      if (held) check("rnd_dout", 32'(dout), 32'(held_w));
      check("rnd_overrun", 32'(ovr_cnt), 32'(e_ovr));
      check("rnd_word_count", 32'(acc_q.size()), 32'(exp_q.size()));
      while (acc_q.size() != 0 && exp_q.size() != 0)
        check("rnd_word", 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
      acc_q.delete();
      exp_q.delete();
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("rnd_frame_err_total", 32'(ferr_cnt), 32'(e_ferr));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
